// File: rtl/mem_request_issuer.sv
// Issues client read/write requests to the memory controller and tracks outstanding reads by address tag.
// Optional latency measurement (stamps + free-running cycle counter) enabled by `define MEM_ISSUER_LATENCY_EN.
module mem_request_issuer #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int DEPTH  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [DATA_W-1:0] req_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_address,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_address,
  output logic [DATA_W-1:0] wr_data,
  input  logic              rd_ret_ack,
  input  logic [ADDR_W-1:0] rd_ret_address,
  input  logic [DATA_W-1:0] rd_ret_data,
  output logic              resp_valid,
  output logic [ADDR_W-1:0] resp_address,
  output logic [DATA_W-1:0] resp_data,
  output logic [CNT_W-1:0]  resp_latency,
  output logic [4:0]        outstanding,
  output logic              unmatched_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DEPTH-1:0]  ent_valid;
  logic [ADDR_W-1:0] ent_addr [DEPTH];

  logic             free_found;
  logic [IDX_W-1:0] free_idx;
  logic             addr_busy;
  logic             hit;
  logic [IDX_W-1:0] hit_idx;
  logic             accept_rd;
  logic             accept_wr;

`ifdef MEM_ISSUER_LATENCY_EN
  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] ent_stamp [DEPTH];
  logic [CNT_W-1:0] resp_latency_q;
`endif

  // Table lookups use only registered entry state, so a slot freed by a return
  // this cycle is not offered to a new read until the following cycle.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    addr_busy  = 1'b0;
    hit        = 1'b0;
    hit_idx    = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(i);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && ent_addr[i] == req_address)
        addr_busy = 1'b1;
      if (ent_valid[i] && ent_addr[i] == rd_ret_address) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    outstanding = '0;
    for (int i = 0; i < DEPTH; i++)
      outstanding = outstanding + 5'(ent_valid[i]);
  end

  assign req_ready = !reset && (req_write || (free_found && !addr_busy));
  assign accept_rd = req_valid && req_ready && !req_write;
  assign accept_wr = req_valid && req_ready && req_write;

  // Hit and accept never target the same slot: a hit entry is valid, a free one is not.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ent_valid     <= '0;
      rd_en         <= 1'b0;
      rd_address    <= '0;
      wr_en         <= 1'b0;
      wr_address    <= '0;
      wr_data       <= '0;
      resp_valid    <= 1'b0;
      resp_address  <= '0;
      resp_data     <= '0;
      unmatched_err <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr[i] <= '0;
      end
`ifdef MEM_ISSUER_LATENCY_EN
      cycle_cnt      <= '0;
      resp_latency_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_stamp[i] <= '0;
      end
`endif
    end else begin
      rd_en      <= accept_rd;
      wr_en      <= accept_wr;
      resp_valid <= 1'b0;
`ifdef MEM_ISSUER_LATENCY_EN
      cycle_cnt <= cycle_cnt + 1'b1;
`endif
      if (accept_wr) begin
        wr_address <= req_address;
        wr_data    <= req_data;
      end
      if (accept_rd) begin
        rd_address          <= req_address;
        ent_valid[free_idx] <= 1'b1;
        ent_addr[free_idx]  <= req_address;
`ifdef MEM_ISSUER_LATENCY_EN
        ent_stamp[free_idx] <= cycle_cnt;
`endif
      end
      if (rd_ret_ack) begin
        if (hit) begin
          ent_valid[hit_idx] <= 1'b0;
          resp_valid         <= 1'b1;
          resp_address       <= rd_ret_address;
          resp_data          <= rd_ret_data;
`ifdef MEM_ISSUER_LATENCY_EN
          resp_latency_q     <= cycle_cnt - ent_stamp[hit_idx];
`endif
        end else begin
          unmatched_err <= 1'b1;
        end
      end
    end
  end

`ifdef MEM_ISSUER_LATENCY_EN
  assign resp_latency = resp_latency_q;
`else
  assign resp_latency = '0;
`endif

endmodule

// File: tb/tb_mem_request_issuer.sv
// Scoreboard bench for mem_request_issuer: the driver pushes expected controller pulses and
// client responses into queues, a negedge monitor pops and compares them.
module tb_mem_request_issuer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_address = '0;
  logic [15:0] req_data = '0;
  logic        rd_en;
  logic [15:0] rd_address;
  logic        wr_en;
  logic [15:0] wr_address;
  logic [15:0] wr_data;
  logic        rd_ret_ack = 1'b0;
  logic [15:0] rd_ret_address = '0;
  logic [15:0] rd_ret_data = '0;
  logic        resp_valid;
  logic [15:0] resp_address;
  logic [15:0] resp_data;
  logic [15:0] resp_latency;
  logic [4:0]  outstanding;
  logic        unmatched_err;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    logic [15:0] lat;
  } resp_t;

  logic [15:0] wr_addr_q[$];
  logic [15:0] wr_data_q[$];
  logic [15:0] rd_addr_q[$];
  resp_t       resp_q[$];
  int          model_table[logic [15:0]];
  bit          model_err = 1'b0;
  int          edge_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  mem_request_issuer #(.ADDR_W(16), .DATA_W(16), .DEPTH(DEPTH), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_data(req_data),
    .rd_en(rd_en), .rd_address(rd_address),
    .wr_en(wr_en), .wr_address(wr_address), .wr_data(wr_data),
    .rd_ret_ack(rd_ret_ack), .rd_ret_address(rd_ret_address), .rd_ret_data(rd_ret_data),
    .resp_valid(resp_valid), .resp_address(resp_address), .resp_data(resp_data),
    .resp_latency(resp_latency), .outstanding(outstanding), .unmatched_err(unmatched_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt++;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, actual, expected, $time);
    end
  endtask

  task automatic flagUnexpected(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got pulse expected none at t=%0t", name, $time);
  endtask

  // Returns are resolved against the table as it stood before this edge, then the accept is added.
  task automatic applyStimulus(input bit valid, input bit write, input logic [15:0] addr,
                               input logic [15:0] data, input bit ret_ack,
                               input logic [15:0] ret_addr, input logic [15:0] ret_data);
    int    next_edge;
    bit    model_ready;
    resp_t r;
    @(negedge clk);
    req_valid      = valid;
    req_write      = write;
    req_address    = addr;
    req_data       = data;
    rd_ret_ack     = ret_ack;
    rd_ret_address = ret_addr;
    rd_ret_data    = ret_data;
    #1;
    next_edge   = edge_cnt + 1;
    model_ready = write ? 1'b1 : (model_table.num() < DEPTH && !model_table.exists(addr));
    if (valid) checkOutput("req_ready", 32'(req_ready), 32'(model_ready));
    if (ret_ack) begin
      if (model_table.exists(ret_addr)) begin
        r.addr = ret_addr;
        r.data = ret_data;
`ifdef MEM_ISSUER_LATENCY_EN
        r.lat = 16'(next_edge - model_table[ret_addr]);
`else
        r.lat = 16'h0;
`endif
        resp_q.push_back(r);
        model_table.delete(ret_addr);
      end else begin
        model_err = 1'b1;
      end
    end
    if (valid && model_ready) begin
      if (write) begin
        wr_addr_q.push_back(addr);
        wr_data_q.push_back(data);
      end else begin
        rd_addr_q.push_back(addr);
        model_table[addr] = next_edge;
      end
    end
    @(posedge clk);
    #1;
    req_valid  = 1'b0;
    rd_ret_ack = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 16'h0, 16'h0, 0, 16'h0, 16'h0);
  endtask

  task automatic doReset();
    reset     = 1'b1;
    req_write = 1'b1;
    req_valid = 1'b1;
    #1;
    checkOutput("rst_outstanding", 32'(outstanding), 32'd0);
    checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
    checkOutput("rst_unmatched_err", 32'(unmatched_err), 32'd0);
    model_table.delete();
    model_err = 1'b0;
    @(posedge clk);
    #1;
    reset     = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
  endtask

  // Scoreboard monitor: every controller pulse and client response must match the head of its queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (wr_en) begin
        if (wr_addr_q.size() == 0) flagUnexpected("wr_en");
        else begin
          checkOutput("wr_address", 32'(wr_address), 32'(wr_addr_q.pop_front()));
          checkOutput("wr_data", 32'(wr_data), 32'(wr_data_q.pop_front()));
        end
      end
      if (rd_en) begin
        if (rd_addr_q.size() == 0) flagUnexpected("rd_en");
        else checkOutput("rd_address", 32'(rd_address), 32'(rd_addr_q.pop_front()));
      end
      if (resp_valid) begin
        if (resp_q.size() == 0) flagUnexpected("resp_valid");
        else begin
          resp_t r;
          r = resp_q.pop_front();
          checkOutput("resp_address", 32'(resp_address), 32'(r.addr));
          checkOutput("resp_data", 32'(resp_data), 32'(r.data));
          checkOutput("resp_latency", 32'(resp_latency), 32'(r.lat));
        end
      end
      checkOutput("outstanding", 32'(outstanding), 32'(model_table.num()));
      checkOutput("unmatched_err", 32'(unmatched_err), 32'(model_err));
    end
  end

  initial begin
    $display("[TB] start");
    req_valid = 1'b1;
    req_write = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("init_req_ready", 32'(req_ready), 32'd0);
    checkOutput("init_rd_en", 32'(rd_en), 32'd0);
    checkOutput("init_wr_en", 32'(wr_en), 32'd0);
    checkOutput("init_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("init_unmatched_err", 32'(unmatched_err), 32'd0);
    checkOutput("init_outstanding", 32'(outstanding), 32'd0);
    checkOutput("init_addr_data", {rd_address, wr_address}, 32'd0);
    checkOutput("init_wr_resp_data", {wr_data, resp_data}, 32'd0);
    checkOutput("init_resp_addr_lat", {resp_address, resp_latency}, 32'd0);
    req_valid = 1'b0;
    req_write = 1'b0;
    reset     = 1'b0;

    applyStimulus(1, 1, 16'h0010, 16'hBEEF, 0, 16'h0, 16'h0);
    idle(2);

    // Read 0x0020 then its return seven edges later.
    applyStimulus(1, 0, 16'h0020, 16'h0, 0, 16'h0, 16'h0);
    idle(6);
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 16'h0020, 16'h1234);
    idle(2);

    // Fill the table, confirm a fifth read stalls while writes still go through.
    for (int i = 1; i <= 4; i++) applyStimulus(1, 0, 16'(i), 16'h0, 0, 16'h0, 16'h0);
    applyStimulus(1, 0, 16'h0005, 16'h0, 0, 16'h0, 16'h0);
    applyStimulus(1, 1, 16'h0077, 16'hA5A5, 0, 16'h0, 16'h0);
    applyStimulus(1, 0, 16'h0005, 16'h0, 1, 16'h0002, 16'h2222);
    applyStimulus(1, 0, 16'h0005, 16'h0, 0, 16'h0, 16'h0);
    applyStimulus(1, 0, 16'h0006, 16'h0, 1, 16'h0001, 16'h1111);
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 16'h0003, 16'h3333);
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 16'h0005, 16'h5555);
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 16'h0004, 16'h4444);
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 16'h0006, 16'h6666);
    idle(2);

    // Same-address read stalls until the cycle after its predecessor returns.
    applyStimulus(1, 0, 16'h0030, 16'h0, 0, 16'h0, 16'h0);
    applyStimulus(1, 0, 16'h0030, 16'h0, 0, 16'h0, 16'h0);
    applyStimulus(1, 0, 16'h0030, 16'h0, 1, 16'h0030, 16'h3030);
    applyStimulus(1, 0, 16'h0030, 16'h0, 0, 16'h0, 16'h0);
    idle(3);
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 16'h0030, 16'hC0DE);
    idle(2);

    // Unmatched return is sticky.
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 16'h0099, 16'hDEAD);
    idle(4);

    doReset();
    idle(1);
    applyStimulus(1, 0, 16'h0040, 16'h0, 0, 16'h0, 16'h0);
    applyStimulus(1, 0, 16'h0041, 16'h0, 0, 16'h0, 16'h0);
    idle(2);
    doReset();
    idle(1);
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 16'h0040, 16'h4040);
    applyStimulus(0, 0, 16'h0, 16'h0, 1, 16'h0041, 16'h4141);
    idle(3);

    checkOutput("wr_queue_drained", 32'(wr_addr_q.size()), 32'd0);
    checkOutput("rd_queue_drained", 32'(rd_addr_q.size()), 32'd0);
    checkOutput("resp_queue_drained", 32'(resp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_request_issuer.md
# mem_request_issuer

Request-issue and return-tracking stage sitting directly upstream of the memory controller. Accepts read/write requests from a client over a valid/ready handshake and drives the controller's `rd_*`/`wr_*` request pins as single-cycle pulses. Keeps a table of outstanding reads tagged by address and matches them against the controller's `rd_ret_*` returns. Delivers completed reads back to the client with their measured latency.

## Interface

Parameters:
- `ADDR_W`, 16, address width (tag width).
- `DATA_W`, 16, data width.
- `DEPTH`, 4, outstanding-read table entries (1..16).
- `CNT_W`, 16, timestamp/latency counter width.

Ports:
- `clk` in 1: single clock; all state on posedge.
- `reset` in 1: asynchronous, active-high.
- `req_valid` in 1: client request valid.
- `req_ready` out 1: stage can accept this cycle.
- `req_write` in 1: 1 = write, 0 = read.
- `req_address` in ADDR_W: request address.
- `req_data` in DATA_W: write data.
- `rd_en` out 1: read pulse to controller.
- `rd_address` out ADDR_W: read address to controller.
- `wr_en` out 1: write pulse to controller.
- `wr_address` out ADDR_W: write address to controller.
- `wr_data` out DATA_W: write data to controller.
- `rd_ret_ack` in 1: controller read-return valid.
- `rd_ret_address` in ADDR_W: return tag (= address).
- `rd_ret_data` in DATA_W: return data.
- `resp_valid` out 1: completed-read pulse to client.
- `resp_address` out ADDR_W: completed-read address.
- `resp_data` out DATA_W: completed-read data.
- `resp_latency` out CNT_W: cycles from accept to return.
- `outstanding` out 5: count of valid table entries.
- `unmatched_err` out 1: sticky; a return matched no entry.

## Operation

- Free-running `cycle_cnt` (CNT_W) increments every clock and wraps modulo 2^CNT_W.
- Accept: `req_valid && req_ready` at a posedge.
- `req_ready` behaviour:
  - Writes: 1 whenever out of reset.
  - Reads: 1 only if a free entry exists AND no valid entry holds `req_address`. Same-address reads are stalled because the tag is the address.
- `req_ready` is computed from registered entry state only. An entry freed this cycle is not reusable until the next cycle.
- Accepted write: `wr_en`/`wr_address`/`wr_data` registered and driven for exactly one cycle. Fire-and-forget: no write tracking.
- Accepted read: lowest-index free entry is loaded with {valid, address, stamp = `cycle_cnt`}; `rd_en`/`rd_address` driven for one cycle.
- Return (`rd_ret_ack`=1 at a posedge): compare `rd_ret_address` against all valid entries.
  - Hit: clear the entry; register `resp_valid`=1, `resp_address`, `resp_data`=`rd_ret_data`, `resp_latency` = (`cycle_cnt` − stamp) mod 2^CNT_W.
  - Miss: set `unmatched_err` (cleared only by reset); no response.
- Accept and return in the same cycle: both processed; `outstanding` nets the change (+1, −1, or 0).
- `rd_en`/`wr_en` low, and addresses/data hold their last value, when no accept occurs.
- Reset (including mid-operation): all entries invalidated; `cycle_cnt`=0. Returns for reads issued before reset arrive as misses and set `unmatched_err`.

## Timing

- Reset values: `req_ready`=0 while `reset` is high; `rd_en`, `wr_en`, `resp_valid`, `unmatched_err` = 0; all address/data/latency outputs = 0; `outstanding`=0.
- Accept at edge N → `rd_en` or `wr_en` high in cycle N..N+1 (asserted after edge N, deasserted after edge N+1).
- Return sampled at edge M → `resp_valid` high after edge M for one cycle.
- `resp_latency` = M − N (edge counts).
- `outstanding` updates one edge after the accept/return that changes it.
- Throughput: one request accepted and one return consumed per cycle.

## Configuration

- `MEM_ISSUER_LATENCY_EN` defined:
  - Stamps and `cycle_cnt` are present.
  - `resp_latency` behaves as in Operation.
- `MEM_ISSUER_LATENCY_EN` undefined:
  - No stamp storage and no `cycle_cnt`.
  - `resp_latency` is constant 0.
  - All other behaviour is identical.

## Test plan

- Reset, then write req addr 0x0010 data 0xBEEF → one-cycle `wr_en` with `wr_address`=0x0010, `wr_data`=0xBEEF; `outstanding` stays 0.
- Read 0x0020 at edge 5, return tag 0x0020 data 0x1234 at edge 12 → `resp_valid` one cycle after edge 12; `resp_data`=0x1234; `resp_latency`=7 (0 without macro).
- DEPTH=4: issue 4 reads 0x1..0x4 back-to-back → `outstanding`=4 and `req_ready`=0 for a 5th read; a write is still accepted. Return 0x2 → `req_ready` rises the next cycle.
- Read 0x0030 outstanding, second read 0x0030 → stalled. Return 0x0030 while re-presenting → accepted the cycle after the return.
- Return tag 0x0099 with no matching entry → `unmatched_err`=1 and stays 1 until reset; no `resp_valid`.
- Assert `reset` with 2 reads outstanding → `outstanding`=0 immediately. Later returns for those tags → `unmatched_err`=1.
